// File: rtl/wb_dest_pkg.sv
// Shared constants and destination-select encodings for the writeback destination tracker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_dest_pkg;

    localparam int ADDR_W_DEF  = 5;
    localparam int DEPTH_DEF   = 4;
    localparam int RA_ADDR_DEF = 31;

    // Destination register source, as driven by the control unit.
    typedef enum logic [1:0] {
        SEL_ALT = 2'b00,
        SEL_RA  = 2'b01,
        SEL_RT  = 2'b10,
        SEL_RD  = 2'b11
    } sel_e;

endpackage

// File: rtl/wb_dest_tracker_if.sv
// Bundle between the control unit (master) and the pending-writeback tracker (slave).
// Latency: n/a (wiring only).
// Backpressure: issue_valid/issue_ready on the push side, commit gated by head_valid on the pop side.
// Ports: issue side (issue_valid, sel, rt_addr, offset, alt_addr, issue_ready), pop side (commit,
//        head_valid, head_addr, count), flush, hazard side (query_a/b, busy_mask, hazard_a/b).
interface wb_dest_tracker_if #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int NREG  = 2 ** ADDR_W;

    logic              flush;
    logic              issue_valid;
    logic [1:0]        sel;
    logic [ADDR_W-1:0] rt_addr;
    logic [15:0]       offset;
    logic [ADDR_W-1:0] alt_addr;
    logic              issue_ready;
    logic              commit;
    logic              head_valid;
    logic [ADDR_W-1:0] head_addr;
    logic [CNT_W-1:0]  count;
    logic [NREG-1:0]   busy_mask;
    logic [ADDR_W-1:0] query_a;
    logic [ADDR_W-1:0] query_b;
    logic              hazard_a;
    logic              hazard_b;

    modport slave (
        input  flush, issue_valid, sel, rt_addr, offset, alt_addr, commit, query_a, query_b,
        output issue_ready, head_valid, head_addr, count, busy_mask, hazard_a, hazard_b
    );

    modport master (
        output flush, issue_valid, sel, rt_addr, offset, alt_addr, commit, query_a, query_b,
        input  issue_ready, head_valid, head_addr, count, busy_mask, hazard_a, hazard_b
    );

endinterface

// File: rtl/wb_dest_select.sv
// Destination register address mux: picks rt, rd (offset[15:11]), link register or alt address.
// Latency: purely combinational.
// Backpressure: none.
// Ports: sel, rt_addr, offset, alt_addr in; dest out.
module wb_dest_select
    import wb_dest_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int RA_ADDR = RA_ADDR_DEF
) (
    input  logic [1:0]        sel,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [15:0]       offset,
    input  logic [ADDR_W-1:0] alt_addr,
    output logic [ADDR_W-1:0] dest
);

    logic [4:0] rd_field;
    assign rd_field = offset[15:11];

    // Only the rd slice of the instruction half-word matters here.
    logic unused_offset_bits;
    assign unused_offset_bits = ^offset[10:0];

    always_comb begin
        dest = alt_addr;
        case (sel)
            SEL_RT:  dest = rt_addr;
            // Size cast truncates to the low bits when the register file is narrower than 32.
            SEL_RD:  dest = ADDR_W'(rd_field);
            SEL_RA:  dest = ADDR_W'(RA_ADDR);
            default: dest = alt_addr;
        endcase
    end

endmodule

// File: rtl/wb_dest_tracker.sv
// In-order pending-writeback FIFO of destination registers with busy mask and two hazard queries.
// Latency: push/pop visible on outputs the cycle after the edge; no same-cycle bypass.
// Backpressure: issue_ready drops at DEPTH entries (not relaxed by same-cycle commit); commit on empty ignored.
// Ports: clk, reset (async active-high), bus (wb_dest_tracker_if.slave).
module wb_dest_tracker
    import wb_dest_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int RA_ADDR = RA_ADDR_DEF
) (
    input  logic              clk,
    input  logic              reset,
    wb_dest_tracker_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 2 ** ADDR_W;

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [ADDR_W-1:0] dest;
    logic              issue_ready;
    logic              head_valid;
    logic              do_push, do_pop;
    logic [NREG-1:0]   busy;

    wb_dest_select #(
        .ADDR_W  (ADDR_W),
        .RA_ADDR (RA_ADDR)
    ) u_select (
        .sel      (bus.sel),
        .rt_addr  (bus.rt_addr),
        .offset   (bus.offset),
        .alt_addr (bus.alt_addr),
        .dest     (dest)
    );

    assign issue_ready = (count_q != CNT_W'(DEPTH));
    assign head_valid  = (count_q != '0);
    assign do_push     = bus.issue_valid && issue_ready;
    assign do_pop      = bus.commit && head_valid;

    always_comb begin
        mem_d    = mem_q;
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            vld_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Push and pop never target the same slot: push needs !full, pop needs !empty,
            // and wr_ptr == rd_ptr only at those two extremes.
            if (do_pop) begin
                vld_d[rd_ptr_q] = 1'b0;
                rd_ptr_d        = rd_ptr_q + PTR_W'(1);
            end
            if (do_push) begin
                mem_d[wr_ptr_q] = dest;
                vld_d[wr_ptr_q] = 1'b1;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Duplicates simply OR together, so a register stays busy until its last entry pops.
    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i]) busy[mem_q[i]] = 1'b1;
        end
        busy[0] = 1'b0; // $zero is never a hazard
    end

    assign bus.issue_ready = issue_ready;
    assign bus.head_valid  = head_valid;
    assign bus.head_addr   = head_valid ? mem_q[rd_ptr_q] : '0;
    assign bus.count       = count_q;
    assign bus.busy_mask   = busy;
    assign bus.hazard_a    = busy[bus.query_a];
    assign bus.hazard_b    = busy[bus.query_b];

endmodule

// File: tb/tb_wb_dest_tracker.sv
// Bench for wb_dest_tracker: queue-based reference model compared every falling edge,
// plus directed literal expectations for select, full, wrap, duplicates, flush and async reset.
// Inputs change 2 time units after the rising edge; outputs are sampled on the falling edge.
module tb_wb_dest_tracker;

    localparam int ADDR_W = 5;
    localparam int DEPTH  = 4;
    localparam int NREG   = 32;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    wb_dest_tracker_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus_if ();

    wb_dest_tracker #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RA_ADDR(31)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    // ---------------- reference model: a plain queue of pending destinations
    logic [ADDR_W-1:0] mq [$];
    bit                m_pop, m_push;
    logic [ADDR_W-1:0] m_dest;

    function automatic logic [ADDR_W-1:0] sel_dest(input logic [1:0] s, input logic [4:0] rt,
                                                   input logic [15:0] off, input logic [4:0] alt);
        case (s)
            2'b10:   return rt;
            2'b11:   return off[15:11];
            2'b01:   return 5'd31;
            default: return alt;
        endcase
    endfunction

    function automatic logic [NREG-1:0] exp_busy();
        logic [NREG-1:0] b;
        b = '0;
        foreach (mq[i]) if (mq[i] != 0) b[mq[i]] = 1'b1;
        return b;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset || bus_if.flush) begin
            mq.delete();
        end else begin
            m_pop  = bus_if.commit && (mq.size() > 0);
            m_push = bus_if.issue_valid && (mq.size() < DEPTH);
            m_dest = sel_dest(bus_if.sel, bus_if.rt_addr, bus_if.offset, bus_if.alt_addr);
            if (m_pop)  void'(mq.pop_front());
            if (m_push) mq.push_back(m_dest);
        end
    end

    always @(negedge clk) begin : cmp
        logic [NREG-1:0] eb;
        eb = exp_busy();
        check("m_count",       64'(bus_if.count),       64'(mq.size()));
        check("m_head_valid",  64'(bus_if.head_valid),  64'(mq.size() != 0));
        check("m_head_addr",   64'(bus_if.head_addr),   64'((mq.size() != 0) ? mq[0] : 5'd0));
        check("m_issue_ready", 64'(bus_if.issue_ready), 64'(mq.size() != DEPTH));
        check("m_busy_mask",   64'(bus_if.busy_mask),   64'(eb));
        check("m_hazard_a",    64'(bus_if.hazard_a),    64'(eb[bus_if.query_a]));
        check("m_hazard_b",    64'(bus_if.hazard_b),    64'(eb[bus_if.query_b]));
    end

    // ---------------- stimulus helpers
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [1:0] s, input logic [4:0] rt, input logic [15:0] off,
                        input logic [4:0] alt);
        bus_if.sel         = s;
        bus_if.rt_addr     = rt;
        bus_if.offset      = off;
        bus_if.alt_addr    = alt;
        bus_if.issue_valid = 1'b1;
        tick();
        bus_if.issue_valid = 1'b0;
    endtask

    task automatic pop();
        bus_if.commit = 1'b1;
        tick();
        bus_if.commit = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset              = 1'b1;
        bus_if.flush       = 1'b0;
        bus_if.issue_valid = 1'b0;
        bus_if.sel         = 2'b00;
        bus_if.rt_addr     = '0;
        bus_if.offset      = '0;
        bus_if.alt_addr    = '0;
        bus_if.commit      = 1'b0;
        bus_if.query_a     = '0;
        bus_if.query_b     = '0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_count",       64'(bus_if.count),       64'd0);
        check("rst_issue_ready", 64'(bus_if.issue_ready), 64'd1);
        check("rst_head_valid",  64'(bus_if.head_valid),  64'd0);
        check("rst_head_addr",   64'(bus_if.head_addr),   64'd0);
        check("rst_busy",        64'(bus_if.busy_mask),   64'd0);

        // four sources, fills the FIFO
        push(2'b10, 5'd5, 16'h0000, 5'd0);
        push(2'b11, 5'd0, 16'h4000, 5'd0);
        push(2'b01, 5'd0, 16'h0000, 5'd0);
        push(2'b00, 5'd0, 16'h0000, 5'd7);
        @(negedge clk);
        check("full_count", 64'(bus_if.count),       64'd4);
        check("full_ready", 64'(bus_if.issue_ready), 64'd0);
        check("sel_busy",   64'(bus_if.busy_mask),   64'h8000_01A0);
        check("sel_head0",  64'(bus_if.head_addr),   64'd5);

        // fifth issue while full is dropped
        push(2'b10, 5'd3, 16'h0000, 5'd0);
        @(negedge clk);
        check("drop_count", 64'(bus_if.count),     64'd4);
        check("drop_busy",  64'(bus_if.busy_mask), 64'h8000_01A0);

        pop();
        @(negedge clk);
        check("sel_head1",   64'(bus_if.head_addr),   64'd8);
        check("pop_ready",   64'(bus_if.issue_ready), 64'd1);
        check("pop_busy1",   64'(bus_if.busy_mask),   64'h8000_0180);
        pop();
        @(negedge clk);
        check("sel_head2",   64'(bus_if.head_addr),   64'd31);
        check("pop_busy2",   64'(bus_if.busy_mask),   64'h8000_0080);
        pop();
        @(negedge clk);
        check("sel_head3",   64'(bus_if.head_addr),   64'd7);
        check("pop_busy3",   64'(bus_if.busy_mask),   64'h0000_0080);
        pop();
        @(negedge clk);
        check("empty_valid", 64'(bus_if.head_valid),  64'd0);
        check("empty_busy",  64'(bus_if.busy_mask),   64'd0);

        // simultaneous push+pop at count=2 across pointer wrap
        push(2'b00, 5'd0, 16'h0000, 5'd1);
        push(2'b00, 5'd0, 16'h0000, 5'd2);
        for (int i = 0; i < 10; i++) begin
            bus_if.sel         = 2'b00;
            bus_if.alt_addr    = 5'(10 + i);
            bus_if.issue_valid = 1'b1;
            bus_if.commit      = 1'b1;
            tick();
        end
        bus_if.issue_valid = 1'b0;
        bus_if.commit      = 1'b0;
        @(negedge clk);
        check("wrap_count", 64'(bus_if.count),     64'd2);
        check("wrap_head",  64'(bus_if.head_addr), 64'd18);
        check("wrap_busy",  64'(bus_if.busy_mask), 64'h000C_0000);
        pop();
        pop();

        // duplicates and $zero
        bus_if.query_a = 5'd9;
        bus_if.query_b = 5'd0;
        push(2'b10, 5'd9, 16'h0000, 5'd0);
        push(2'b10, 5'd9, 16'h0000, 5'd0);
        @(negedge clk);
        check("dup_haz0", 64'(bus_if.hazard_a), 64'd1);
        pop();
        @(negedge clk);
        check("dup_haz1", 64'(bus_if.hazard_a), 64'd1);
        pop();
        @(negedge clk);
        check("dup_haz2", 64'(bus_if.hazard_a), 64'd0);
        push(2'b00, 5'd0, 16'h0000, 5'd0);
        @(negedge clk);
        check("zero_busy",  64'(bus_if.busy_mask), 64'd0);
        check("zero_hazb",  64'(bus_if.hazard_b),  64'd0);
        check("zero_count", 64'(bus_if.count),     64'd1);
        pop();
        pop(); // commit while empty: ignored
        @(negedge clk);
        check("underflow_count", 64'(bus_if.count), 64'd0);

        // flush beats same-cycle push and pop
        push(2'b00, 5'd0, 16'h0000, 5'd3);
        push(2'b00, 5'd0, 16'h0000, 5'd4);
        bus_if.flush       = 1'b1;
        bus_if.issue_valid = 1'b1;
        bus_if.sel         = 2'b10;
        bus_if.rt_addr     = 5'd6;
        bus_if.commit      = 1'b1;
        tick();
        bus_if.flush       = 1'b0;
        bus_if.issue_valid = 1'b0;
        bus_if.commit      = 1'b0;
        @(negedge clk);
        check("flush_count", 64'(bus_if.count),      64'd0);
        check("flush_busy",  64'(bus_if.busy_mask),  64'd0);
        check("flush_valid", 64'(bus_if.head_valid), 64'd0);

        // async reset mid-clock with two entries queued
        push(2'b00, 5'd0, 16'h0000, 5'd12);
        push(2'b00, 5'd0, 16'h0000, 5'd13);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("arst_count", 64'(bus_if.count),       64'd0);
        check("arst_busy",  64'(bus_if.busy_mask),   64'd0);
        check("arst_ready", 64'(bus_if.issue_ready), 64'd1);
        check("arst_valid", 64'(bus_if.head_valid),  64'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        tick();
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_dest_tracker.md
Name: wb_dest_tracker

Overview:
- Parametrised successor to the write-register destination mux in the multicycle MIPS datapath.
- Selects the destination register address from the same four sources, then queues it in an in-order, DEPTH-entry pending-writeback FIFO.
- Exposes a busy mask and two hazard query ports for the control unit, and presents the oldest pending destination to the register-file write port.

Parameters:
ADDR_W, 5, register address width (register file has 2**ADDR_W entries)
DEPTH, 4, maximum in-flight pending writes (power of two, >=2)
RA_ADDR, 31, link-register address written for sel=2'b01

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  discard all pending entries
issue_valid  input  1  push the selected destination this cycle
sel  input  2  destination source select
rt_addr  input  ADDR_W  instruction rt field
offset  input  16  instruction low half; rd = offset[15:11] (low ADDR_W bits of that slice when ADDR_W<5)
alt_addr  input  ADDR_W  third explicit source
issue_ready  output  1  FIFO can accept a push
commit  input  1  pop oldest entry (write performed)
head_valid  output  1  FIFO non-empty
head_addr  output  ADDR_W  oldest pending destination
count  output  $clog2(DEPTH)+1  number of pending entries
busy_mask  output  2**ADDR_W  bit r set while register r is pending
query_a  input  ADDR_W  source register A (rs)
query_b  input  ADDR_W  source register B (rt)
hazard_a  output  1  busy_mask[query_a]
hazard_b  output  1  busy_mask[query_b]

Behaviour:
- Destination select (combinational):
  - sel=2'b10 -> rt_addr
  - sel=2'b11 -> offset[15:11]
  - sel=2'b01 -> RA_ADDR
  - sel=2'b00 -> alt_addr
- Reset (async): pointers=0, count=0, all entry valids=0. Hence head_valid=0, head_addr=0, busy_mask=0, hazard_a/b=0, issue_ready=1.
- Storage: circular buffer of DEPTH {addr}, read/write pointers of $clog2(DEPTH) bits; pointers wrap modulo DEPTH.
- Push: occurs on a clock edge when issue_valid && issue_ready. The selected address is written at wr_ptr, wr_ptr++, count++.
- issue_valid while !issue_ready: push dropped, no state change. The issuer must hold off.
- issue_ready = (count != DEPTH). It is not relaxed by a same-cycle commit.
- Pop: occurs on a clock edge when commit && head_valid. rd_ptr++, count--.
- commit while empty: ignored.
- Simultaneous push and pop (not full, not empty): both take effect and count is unchanged.
- Simultaneous push and pop when count=1: the new entry becomes head next cycle.
- head_addr = entry at rd_ptr (combinational from state). Value when empty: 0.
- busy_mask: combinational OR over valid entries of one-hot(addr). Bit 0 is forced 0, because $zero is never a hazard; address-0 entries are still queued and popped.
- Duplicate destinations: busy stays set until the last matching entry is popped.
- Latency: a pushed destination appears in busy_mask/hazards the cycle after the push edge and clears the cycle after its pop edge. No same-cycle bypass.
- hazard_a/b: combinational from busy_mask and queries.
- flush: synchronous. It has priority over push and pop in the same cycle. Pointers and count go to 0, so busy_mask=0 next cycle.
- reset asserted mid-operation: immediate return to reset state, regardless of clk.

Decomposition:
- Package wb_dest_pkg: ADDR_W default, RA_ADDR, sel encodings (SEL_ALT=2'b00, SEL_RA=2'b01, SEL_RT=2'b10, SEL_RD=2'b11).
- One combinational sub-module, wb_dest_select (sel, rt_addr, offset, alt_addr -> dest), reusable standalone in the single-cycle path.
- FIFO and busy logic stay in wb_dest_tracker.

Test Plan:
- Reset: assert reset mid-clock with 2 entries queued -> outputs drop immediately to count=0, busy_mask=0, issue_ready=1, head_valid=0.
- Select: issue sel=10 rt=5, sel=11 offset=16'h4000, sel=01, sel=00 alt=7 -> head_addr sequence 5, 8, 31, 7 on successive commits; busy bits {5,8,31,7} set, then clear one per pop.
- Full: 4 pushes -> count=4, issue_ready=0. A fifth issue_valid is dropped. A pop then frees space: issue_ready=1 next cycle.
- Simultaneous push+pop at count=2 -> count stays 2, FIFO order preserved across pointer wrap (run 10 cycles, DEPTH=4).
- Hazard/duplicates: push 9, push 9, query_a=9 -> hazard_a=1 after first pop, 0 after second. Push 0 -> busy_mask[0]=0, hazard_b (query_b=0)=0, count=1.
- Flush with issue_valid and commit asserted same cycle -> next cycle count=0, busy_mask=0, the issued address is not queued.
